// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter and sequencer for the shared 8-bit ROM/RAM bus.
// Every access runs IDLE -> SETUP -> STROBE (WAIT_CYCLES+1 cycles) -> DONE.
// A ROM write skips the bus and goes straight to DONE with err set.
// All outputs are registered. They are computed from the next state, so each
// output matches the state the FSM is in during that same cycle.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
// When the macro is undefined, m0 has fixed priority on ties.
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic       m0_ram,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_ack,
  output logic       m0_err,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic       m1_ram,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_ack,
  output logic       m1_err,
  output logic [7:0] rdata,
  output logic [7:0] AB,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  input  logic [7:0] DB_in,
  output logic       ROM_en,
  output logic       ROM_read,
  output logic       RAM_en,
  output logic       RAM_read,
  output logic       RAM_write,
  output logic [1:0] gnt,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic        own_q, own_d;
  logic        we_q, we_d;
  logic        ram_q, ram_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [2:0]  wait_q, wait_d;
  logic        win;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;
`endif

  logic [7:0]  ab_q, ab_d;
  logic [7:0]  db_out_q, db_out_d;
  logic        db_oe_q, db_oe_d;
  logic        rom_en_q, rom_en_d;
  logic        rom_read_q, rom_read_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_read_q, ram_read_d;
  logic        ram_write_q, ram_write_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        busy_q, busy_d;

  // Next-state, arbitration, access latching and registered-output decode
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    we_d        = we_q;
    ram_d       = ram_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    win         = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    ab_d        = ab_q;
    db_out_d    = db_out_q;
    rdata_d     = rdata_q;
    db_oe_d     = 1'b0;
    rom_en_d    = 1'b0;
    rom_read_d  = 1'b0;
    ram_en_d    = 1'b0;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ack_d       = 2'b00;
    err_d       = 2'b00;
    gnt_d       = 2'b00;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          win    = (m0_req && m1_req) ? ~last_q : m1_req;
          last_d = win;
`else
          win    = m1_req && !m0_req;
`endif
          own_d   = win;
          we_d    = win ? m1_we    : m0_we;
          ram_d   = win ? m1_ram   : m0_ram;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          state_d = (we_d && !ram_d) ? DONE : SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
        wait_d  = 3'd0;
      end
      STROBE: begin
        if (wait_q == WAIT_LAST) begin
          state_d = DONE;
          if (!we_q) rdata_d = DB_in;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != IDLE) begin
      busy_d = 1'b1;
      gnt_d  = own_d ? 2'b10 : 2'b01;
    end
    if (state_d == SETUP || state_d == STROBE) begin
      ab_d     = addr_d;
      rom_en_d = !ram_d;
      ram_en_d = ram_d;
      if (we_d) begin
        db_out_d = wdata_d;
        db_oe_d  = 1'b1;
      end
    end
    if (state_d == STROBE) begin
      rom_read_d  = !ram_d && !we_d;
      ram_read_d  = ram_d && !we_d;
      ram_write_d = ram_d && we_d;
    end
    if (state_d == DONE) begin
      ack_d = own_d ? 2'b10 : 2'b01;
      if (we_d && !ram_d) err_d = own_d ? 2'b10 : 2'b01;
    end
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
      ab_q        <= 8'h00;
      db_out_q    <= 8'h00;
      db_oe_q     <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_read_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ack_q       <= 2'b00;
      err_q       <= 2'b00;
      rdata_q     <= 8'h00;
      gnt_q       <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
      ab_q        <= ab_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
      rom_en_q    <= rom_en_d;
      rom_read_q  <= rom_read_d;
      ram_en_q    <= ram_en_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
    end
  end

  // Latched access descriptor and wait counter; only meaningful while busy
  always_ff @(posedge clk) begin
    own_q   <= own_d;
    we_q    <= we_d;
    ram_q   <= ram_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wait_q  <= wait_d;
  end

  assign AB        = ab_q;
  assign DB_out    = db_out_q;
  assign DB_oe     = db_oe_q;
  assign ROM_en    = rom_en_q;
  assign ROM_read  = rom_read_q;
  assign RAM_en    = ram_en_q;
  assign RAM_read  = ram_read_q;
  assign RAM_write = ram_write_q;
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign rdata     = rdata_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: one instance with WAIT_CYCLES=0
// and one with WAIT_CYCLES=3, both sharing the same stimulus.
module tb_mem_bus_arbiter;

  logic       clk, rst_n;
  logic       m0_req, m0_we, m0_ram, m1_req, m1_we, m1_ram;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata, DB_in;

  logic       m0_ack, m0_err, m1_ack, m1_err, DB_oe;
  logic       ROM_en, ROM_read, RAM_en, RAM_read, RAM_write, busy;
  logic [7:0] rdata, AB, DB_out;
  logic [1:0] gnt;

  logic       w_m0_ack, w_m0_err, w_m1_ack, w_m1_err, w_DB_oe;
  logic       w_ROM_en, w_ROM_read, w_RAM_en, w_RAM_read, w_RAM_write, w_busy;
  logic [7:0] w_rdata, w_AB, w_DB_out;
  logic [1:0] w_gnt;

  int n_chk  = 0;
  int n_pass = 0;

  mem_bus_arbiter #(.WAIT_CYCLES(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_ram(m0_ram), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_ram(m1_ram), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .rdata(rdata), .AB(AB), .DB_out(DB_out), .DB_oe(DB_oe), .DB_in(DB_in),
    .ROM_en(ROM_en), .ROM_read(ROM_read), .RAM_en(RAM_en), .RAM_read(RAM_read),
    .RAM_write(RAM_write), .gnt(gnt), .busy(busy)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(3)) u_dut_w (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_ram(m0_ram), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(w_m0_ack), .m0_err(w_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_ram(m1_ram), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(w_m1_ack), .m1_err(w_m1_err),
    .rdata(w_rdata), .AB(w_AB), .DB_out(w_DB_out), .DB_oe(w_DB_oe), .DB_in(DB_in),
    .ROM_en(w_ROM_en), .ROM_read(w_ROM_read), .RAM_en(w_RAM_en), .RAM_read(w_RAM_read),
    .RAM_write(w_RAM_write), .gnt(w_gnt), .busy(w_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // Advance one clock and land just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_req = 1'b0;
    m1_req = 1'b0;
    rst_n  = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
  endtask

  logic [1:0] exp_gnt [4];
  int         rd_cnt;

  initial begin
    rst_n = 1'b0; DB_in = 8'h00;
    m0_req = 1'b0; m0_we = 1'b0; m0_ram = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_we = 1'b0; m1_ram = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
    step();
    step();

    // Reset state
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_AB", 32'(AB), 32'h0);
    chk("rst_DB_out", 32'(DB_out), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_strobes", 32'({DB_oe, ROM_en, ROM_read, RAM_en, RAM_read, RAM_write, m0_ack, m1_ack}), 32'h0);
    rst_n = 1'b1;

    // m0 reads RAM[0x10], memory returns 0xA5
    DB_in = 8'hA5;
    m0_req = 1'b1; m0_we = 1'b0; m0_ram = 1'b1; m0_addr = 8'h10;
    step();
    chk("rd_c1_en", 32'({RAM_en, RAM_read, ROM_en}), 32'b100);
    chk("rd_c1_AB", 32'(AB), 32'h10);
    chk("rd_c1_gnt", 32'({gnt, busy}), 32'b011);
    step();
    chk("rd_c2_en", 32'({RAM_en, RAM_read, ROM_en, DB_oe}), 32'b1100);
    chk("rd_c2_ack", 32'(m0_ack), 32'h0);
    step();
    chk("rd_c3_ack", 32'({m0_ack, m0_err, m1_ack}), 32'b100);
    chk("rd_c3_rdata", 32'(rdata), 32'hA5);
    chk("rd_c3_off", 32'({RAM_en, RAM_read}), 32'b00);
    m0_req = 1'b0;
    DB_in = 8'h00;
    step();
    chk("rd_c4_idle", 32'({busy, gnt, m0_ack}), 32'h0);
    chk("rd_c4_hold", 32'(rdata), 32'hA5);

    // m1 writes 0x3C to RAM[0xFF]
    m1_req = 1'b1; m1_we = 1'b1; m1_ram = 1'b1; m1_addr = 8'hFF; m1_wdata = 8'h3C;
    step();
    chk("wr_c1_bus", 32'({AB, DB_out, DB_oe}), {15'h0, 8'hFF, 8'h3C, 1'b1});
    chk("wr_c1_str", 32'({RAM_en, RAM_write, RAM_read}), 32'b100);
    chk("wr_c1_gnt", 32'(gnt), 32'b10);
    step();
    chk("wr_c2_str", 32'({RAM_en, RAM_write, RAM_read, DB_oe}), 32'b1101);
    chk("wr_c2_bus", 32'({AB, DB_out}), {16'h0, 8'hFF, 8'h3C});
    step();
    chk("wr_c3_ack", 32'({m1_ack, m1_err, m0_ack}), 32'b100);
    chk("wr_c3_off", 32'({RAM_write, RAM_en, DB_oe}), 32'b000);
    chk("wr_c3_rdata", 32'(rdata), 32'hA5);
    m1_req = 1'b0; m1_we = 1'b0;
    step();

    // m0 writes to ROM[0x00]: rejected
    m0_req = 1'b1; m0_we = 1'b1; m0_ram = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h11;
    step();
    chk("rej_c1_ack", 32'({m0_ack, m0_err}), 32'b11);
    chk("rej_c1_str", 32'({ROM_en, ROM_read, RAM_en, DB_oe}), 32'b0000);
    chk("rej_c1_AB", 32'(AB), 32'hFF);
    m0_req = 1'b0; m0_we = 1'b0;
    step();
    chk("rej_c2_idle", 32'({m0_ack, m0_err, busy, ROM_en, ROM_read}), 32'h0);

    // Both masters read ROM continuously from reset, four accesses
`ifdef ARB_ROUND_ROBIN_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    m0_we = 1'b0; m0_ram = 1'b0; m0_addr = 8'h20;
    m1_we = 1'b0; m1_ram = 1'b0; m1_addr = 8'h30;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("arb_gnt%0d", i), 32'(gnt), 32'(exp_gnt[i]));
      chk($sformatf("arb_rom%0d", i), 32'({ROM_en, RAM_en}), 32'b10);
      step();
      step();
      chk($sformatf("arb_ack%0d", i), 32'({m1_ack, m0_ack}), 32'(exp_gnt[i]));
      step();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();

    // WAIT_CYCLES=3 ROM read; DB_in changes every cycle
    do_reset();
    DB_in = 8'h50;
    m0_req = 1'b1; m0_we = 1'b0; m0_ram = 1'b0; m0_addr = 8'h42;
    rd_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (w_ROM_read) rd_cnt++;
      if (c == 1) chk("w3_c1_setup", 32'({w_ROM_en, w_ROM_read, w_AB}), {22'h0, 2'b10, 8'h42});
      if (c == 5) chk("w3_c5_noack", 32'({w_m0_ack, w_ROM_read}), 32'b01);
      if (c == 6) begin
        chk("w3_c6_ack", 32'({w_m0_ack, w_m0_err, w_ROM_read, w_ROM_en}), 32'b1000);
        chk("w3_c6_rdata", 32'(w_rdata), 32'h55);
        m0_req = 1'b0;
      end
      if (c == 7) chk("w3_c7_idle", 32'({w_busy, w_m0_ack}), 32'b00);
      DB_in = 8'(32'h50 + c);
    end
    chk("w3_rd_cycles", 32'(rd_cnt), 32'd4);
    step();
    step();

    // Reset during STROBE of a RAM write aborts it
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_ram = 1'b1; m1_addr = 8'h77; m1_wdata = 8'h99;
    step();
    step();
    chk("abrt_c2_wr", 32'(RAM_write), 32'h1);
    rst_n = 1'b0;
    step();
    chk("abrt_c3_off", 32'({RAM_write, RAM_en, DB_oe, busy, gnt, m1_ack}), 32'h0);
    m1_req = 1'b0; m1_we = 1'b0;
    rst_n = 1'b1;
    step();
    chk("abrt_c4_noack", 32'({m1_ack, m0_ack, busy}), 32'h0);
    m0_we = 1'b0; m0_ram = 1'b0; m0_addr = 8'h01;
    m1_ram = 1'b0; m1_addr = 8'h02;
    m0_req = 1'b1; m1_req = 1'b1;
    step();
    chk("abrt_tie_gnt", 32'({gnt, AB}), {22'h0, 2'b01, 8'h01});
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
